// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined signed multiply-accumulate for conv layers.
// Sums ACC_LEN products, then rounds, shifts and saturates one result.
module cnn_mac_pipe #(
    parameter int A_W       = 14,
    parameter int B_W       = 7,
    parameter int NUM_STAGE = 3,
    parameter int ACC_W     = 32,
    parameter int ACC_LEN   = 9,
    parameter int SHIFT     = 7,
    parameter int OUT_W     = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat
);

    localparam int PW = A_W + B_W;
    localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);
    localparam logic signed [ACC_W:0] ONE = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] RND = (SHIFT > 0) ? (ONE <<< RSH) : '0;
    localparam logic signed [ACC_W:0] MAXV =
        {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV =
        {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                    en;
    logic signed [PW-1:0]    a_x;
    logic signed [PW-1:0]    b_x;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    pd_q [NUM_STAGE];
    logic [NUM_STAGE-1:0]    pv_q;
    logic [CW-1:0]           cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W:0]   rnd_sum;
    logic signed [ACC_W:0]   shifted;
    logic                    sat_hi;
    logic                    sat_lo;
    logic [OUT_W-1:0]        clip;
    logic                    fire;
    logic                    load;

    // Whole datapath freezes only while a result waits on the consumer.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // Exact signed product at full width.
    assign a_x  = PW'($signed(in_a));
    assign b_x  = PW'($signed(in_b));
    assign prod = a_x * b_x;

    // Accumulate, round half up, arithmetic shift and clip.
    assign ext     = ACC_W'(pd_q[NUM_STAGE-1]);
    assign base    = (cnt == '0) ? '0 : acc;
    assign sum     = base + ext;
    assign rnd_sum = (ACC_W+1)'(sum) + RND;
    assign shifted = rnd_sum >>> SHIFT;
    assign sat_hi  = shifted > MAXV;
    assign sat_lo  = shifted < MINV;
    assign clip    = sat_hi ? MAXV[OUT_W-1:0] :
                     sat_lo ? MINV[OUT_W-1:0] :
                     shifted[OUT_W-1:0];

    assign fire = en && pv_q[NUM_STAGE-1];
    assign load = fire && (cnt == LAST);

    // Multiplier pipeline: product and valid advance together on enable.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pv_q <= '0;
            for (int i = 0; i < NUM_STAGE; i++) begin
                pd_q[i] <= '0;
            end
        end else if (en) begin
            pv_q[0] <= in_valid;
            pd_q[0] <= prod;
            for (int i = 1; i < NUM_STAGE; i++) begin
                pv_q[i] <= pv_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
        end
    end

    // Window counter and running sum; bubbles leave both untouched.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (fire) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Result register: a new load overrides a same-cycle consume.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= clip;
            out_sat   <= sat_hi | sat_lo;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// tb_cnn_mac_pipe: scoreboard bench for the pipelined MAC.
// Model results are queued on accept and checked on each consume.
module tb_cnn_mac_pipe;

    localparam int NS = 3;
    localparam int AL = 9;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
    } exp_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] in_a = '0;
    logic [6:0]  in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_sat;

    exp_t              sb[$];
    int                total = 0;
    int                bad = 0;
    int                cyc = 0;
    int                done_cyc = 0;
    int                m_cnt = 0;
    logic signed [31:0] m_acc = '0;

    always #5 ap_clk = ~ap_clk;

    cnn_mac_pipe #(
        .A_W(14), .B_W(7), .NUM_STAGE(NS), .ACC_W(32),
        .ACC_LEN(AL), .SHIFT(7), .OUT_W(16)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_sat(out_sat)
    );

    function automatic exp_t golden(input logic signed [31:0] s);
        longint r;
        exp_t   e;
        r = (longint'(s) + 64) >>> 7;
        if (r > 32767) begin
            e.d = 16'h7FFF;
            e.s = 1'b1;
        end else if (r < -32768) begin
            e.d = 16'h8000;
            e.s = 1'b1;
        end else begin
            e.d = r[15:0];
            e.s = 1'b0;
        end
        return e;
    endfunction

    task automatic model_accept(input logic [13:0] a, input logic [6:0] b);
        logic signed [31:0] p;
        logic signed [31:0] s;
        p = $signed({{18{a[13]}}, a}) * $signed({{25{b[6]}}, b});
        s = ((m_cnt == 0) ? 32'sd0 : m_acc) + p;
        if (m_cnt == AL - 1) begin
            sb.push_back(golden(s));
            m_cnt = 0;
            done_cyc = cyc;
        end else begin
            m_acc = s;
            m_cnt++;
        end
    endtask

    task automatic step(input bit v, input logic [13:0] a,
                        input logic [6:0] b, input bit ordy,
                        output bit acc, output bit got, output exp_t obs);
        @(negedge ap_clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        cyc++;
        acc   = in_valid && in_ready;
        got   = out_valid && out_ready;
        obs.d = out_data;
        obs.s = out_sat;
        if (acc) model_accept(a, b);
    endtask

    task automatic test_reset;
        ap_rst_n = 1'b0;
        #12;
        total += 3;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid got=%b want=0", out_valid);
        end
        if (out_data !== 16'h0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", out_data);
        end
        if (out_sat !== 1'b0) begin
            bad++;
            $display("FAIL reset_sat got=%b want=0", out_sat);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_directed(input string nm,
                                 input logic [13:0] a0, input logic [6:0] b0,
                                 input logic [13:0] a1, input logic [6:0] b1,
                                 input logic [15:0] wd, input logic ws);
        bit   ac, g;
        exp_t o, e;
        int   vcount = 0;
        for (int i = 0; i < AL + 8; i++) begin
            step(i < AL, (i == 0) ? a0 : a1, (i == 0) ? b0 : b1, 1'b1,
                 ac, g, o);
            if (out_valid) vcount++;
            if (g) begin
                total += 3;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL %s_extra got=%0d/%b want=none",
                             nm, $signed(o.d), o.s);
                end else begin
                    e = sb.pop_front();
                    if (o !== e) begin
                        bad++;
                        $display("FAIL %s_model got=%0d/%b want=%0d/%b",
                                 nm, $signed(o.d), o.s, $signed(e.d), e.s);
                    end
                end
                if (o.d !== wd || o.s !== ws) begin
                    bad++;
                    $display("FAIL %s_const got=%0d/%b want=%0d/%b",
                             nm, $signed(o.d), o.s, $signed(wd), ws);
                end
                if (cyc - done_cyc !== NS + 1) begin
                    bad++;
                    $display("FAIL %s_latency got=%0d want=%0d",
                             nm, cyc - done_cyc - 1, NS);
                end
            end
        end
        total++;
        if (vcount !== 1) begin
            bad++;
            $display("FAIL %s_vcycles got=%0d want=1", nm, vcount);
        end
    endtask

    task automatic test_backpressure;
        bit          ac, g, rel = 1'b0;
        exp_t        o, e;
        logic [15:0] held = '0;
        int          fed = 0, stall = 0, ngot = 0, guard = 0;
        while ((fed < 5 * AL || sb.size() > 0) && guard < 500) begin
            guard++;
            step(fed < 5 * AL, 14'($urandom), 7'($urandom), rel, ac, g, o);
            if (ac) fed++;
            if (!rel && out_valid) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_ready got=%b want=0", in_ready);
                end
                if (stall == 0) begin
                    held = o.d;
                end else begin
                    total++;
                    if (o.d !== held) begin
                        bad++;
                        $display("FAIL bp_hold got=%h want=%h", o.d, held);
                    end
                end
                stall++;
                if (stall == 10) rel = 1'b1;
            end
            if (g) begin
                ngot++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra got=%0d want=none", $signed(o.d));
                end else begin
                    e = sb.pop_front();
                    if (o !== e) begin
                        bad++;
                        $display("FAIL bp_model got=%0d/%b want=%0d/%b",
                                 $signed(o.d), o.s, $signed(e.d), e.s);
                    end
                end
            end
        end
        total++;
        if (ngot !== 5 || guard >= 500) begin
            bad++;
            $display("FAIL bp_count got=%0d want=5 guard=%0d", ngot, guard);
        end
    endtask

    task automatic test_random;
        bit   ac, g;
        exp_t o, e;
        int   fed = 0, ngot = 0, guard = 0;
        while ((fed < 1000 * AL || sb.size() > 0) && guard < 60000) begin
            guard++;
            step((fed < 1000 * AL) && ($urandom_range(0, 1) == 1),
                 14'($urandom), 7'($urandom),
                 $urandom_range(0, 3) != 0, ac, g, o);
            if (ac) fed++;
            if (g) begin
                ngot++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL rnd_extra got=%0d want=none", $signed(o.d));
                end else begin
                    e = sb.pop_front();
                    if (o !== e) begin
                        bad++;
                        $display("FAIL rnd_model got=%0d/%b want=%0d/%b",
                                 $signed(o.d), o.s, $signed(e.d), e.s);
                    end
                end
            end
        end
        total++;
        if (ngot !== 1000 || guard >= 60000) begin
            bad++;
            $display("FAIL rnd_count got=%0d want=1000 guard=%0d", ngot, guard);
        end
    endtask

    task automatic test_rst_mid;
        bit   ac, g;
        exp_t o;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 14'd100, 7'd3, 1'b1, ac, g, o);
        end
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        ap_rst_n = 1'b0;
        #1;
        total += 4;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_valid got=%b want=0", out_valid);
        end
        if (out_data !== 16'h0) begin
            bad++;
            $display("FAIL rstmid_data got=%h want=0", out_data);
        end
        if (out_sat !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_sat got=%b want=0", out_sat);
        end
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_ready got=%b want=1", in_ready);
        end
        m_cnt = 0;
        m_acc = '0;
        sb.delete();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        test_directed("rstmid_fresh", 14'd100, 7'd3, 14'd100, 7'd3,
                      16'd21, 1'b0);
    endtask

    initial begin
        test_reset;
        test_directed("basic", 14'd100, 7'd3, 14'd100, 7'd3, 16'd21, 1'b0);
        test_directed("sat_hi", 14'd8191, 7'd63, 14'd8191, 7'd63,
                      16'h7FFF, 1'b1);
        test_directed("sat_lo", 14'h2000, 7'd63, 14'h2000, 7'd63,
                      16'h8000, 1'b1);
        test_directed("round_neg", 14'h3FFF, 7'd1, 14'h3FFF, 7'd1,
                      16'd0, 1'b0);
        test_directed("neg_neg", 14'h2000, 7'h40, 14'd0, 7'd0,
                      16'd4096, 1'b0);
        test_backpressure;
        test_random;
        test_rst_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
